mux_arb_n: RTL
==============

MUX_ARB_N -- requirements
Module: mux_arb_n

Interface
- REQ-001 SHALL have parameter WIDTH, default 24: data width per channel.
- REQ-002 SHALL have parameter N, default 4: channel count, legal range 2..16.
- REQ-003 SHALL have parameter MODE, default 0: 0 = select-driven, 1 = round-robin.
- REQ-004 SHALL have `Clock`, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-005 SHALL have `Reset`, input, 1 bit: synchronous, active-high reset.
- REQ-006 SHALL have `Hyrja`, input, N*WIDTH bits: channel i occupies bits [i*WIDTH +: WIDTH].
- REQ-007 SHALL have `HyrjaValid`, input, N bits: per-channel valid.
- REQ-008 SHALL have `HyrjaGati`, output, N bits: per-channel ready; combinational.
- REQ-009 SHALL have `S`, input, SW = max(1, clog2(N)) bits: channel select, used only when MODE=0.
- REQ-010 SHALL have `Dalja`, output, WIDTH bits: registered output data.
- REQ-011 SHALL have `DaljaValid`, output, 1 bit: output valid.
- REQ-012 SHALL have `DaljaGati`, input, 1 bit: downstream ready.
- REQ-013 SHALL have `DaljaKanali`, output, SW bits: index of the channel that sourced `Dalja`.

Function
- REQ-014 SHALL define load = ~DaljaValid | DaljaGati; the output register accepts new data only when load=1.
- REQ-015 In MODE=0, SHALL grant channel S when HyrjaValid[S]=1; no grant if S >= N or HyrjaValid[S]=0.
- REQ-016 In MODE=1, SHALL grant the first valid channel searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1; no grant if HyrjaValid = 0.
- REQ-017 SHALL drive HyrjaGati[i] = load & grant[i], so at most one bit is high per cycle.
- REQ-018 On a transfer (HyrjaValid[i] & HyrjaGati[i]), SHALL register Dalja <= channel i data, DaljaKanali <= i and DaljaValid <= 1, with latency 1 cycle.
- REQ-019 On a transfer in MODE=1, SHALL update ptr <= (i+1) mod N, so N-1 wraps to 0.
- REQ-020 ptr SHALL be unchanged in cycles without a transfer and in MODE=0.
- REQ-021 When load=1 and there is no grant, SHALL clear DaljaValid to 0; Dalja and DaljaKanali hold their old values.
- REQ-022 While DaljaValid=1 and DaljaGati=0, SHALL hold Dalja, DaljaKanali and DaljaValid stable and drive all HyrjaGati low.
- REQ-023 SHALL sustain one transfer per cycle when DaljaGati is held at 1, with no bubble cycles.
- REQ-024 Simultaneous output drain and new grant in the same cycle SHALL replace the output register; no beat is lost or duplicated.
- REQ-025 A change of S while DaljaValid=1 SHALL NOT affect the already-registered beat.

Reset
- REQ-026 While Reset=1 at a rising edge, SHALL set DaljaValid=0, Dalja=0, DaljaKanali=0 and ptr=0.
- REQ-027 While Reset=1, SHALL hold HyrjaGati at 0.
- REQ-028 A beat pending at the output when Reset asserts SHALL be discarded.
- REQ-029 A transfer offered in a cycle where Reset=1 SHALL NOT be accepted.
- REQ-030 SHALL resume normal operation in the first cycle after Reset deasserts.

Structure
- REQ-031 The shared package SHALL hold the default data width (24), the MODE_SELECT=0 and MODE_RR=1 constants, and the select-width function.
- REQ-032 The round-robin search SHALL be one sub-module, rr_arbiter (inputs: request vector, ptr; output: one-hot grant), instantiated only when MODE=1.
- REQ-033 The data path SHALL be a single registered stage; no additional storage is permitted.

Verification
- REQ-034 MODE=0, N=4: S=2, HyrjaValid=4'b0100, channel 2 = 24'hABCDEF, DaljaGati=1 -> next cycle Dalja=24'hABCDEF, DaljaKanali=2, DaljaValid=1.
- REQ-035 MODE=1, N=4: HyrjaValid=4'b1111 held, DaljaGati=1 -> DaljaKanali sequence 0,1,2,3,0 on consecutive cycles.
- REQ-036 MODE=1: ptr=3, HyrjaValid=4'b0010 -> channel 1 granted, then ptr=2.
- REQ-037 Backpressure: DaljaValid=1 with DaljaGati=0 for 3 cycles -> Dalja stable and HyrjaGati=0 for all 3 cycles; DaljaGati=1 -> a new beat appears the next cycle.
- REQ-038 MODE=0, N=3: S=3 -> HyrjaGati=0 and DaljaValid falls to 0 after a drain.
- REQ-039 Reset asserted with DaljaValid=1 and ptr=2 -> next cycle DaljaValid=0, Dalja=0, and the first grant after reset goes to channel 0 when all channels are valid.

Source files
------------

// File: rtl/mux_arb_n_pkg.sv
// rtl/mux_arb_n_pkg.sv - shared constants and helpers for the N-channel arbitrated mux
package mux_arb_n_pkg;

    localparam int DEFAULT_WIDTH = 24;
    localparam int MODE_SELECT   = 0;
    localparam int MODE_RR       = 1;

    // Select/index width; a two-channel (or smaller) mux still needs one bit.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_arb_n_rr_arbiter.sv
// rtl/mux_arb_n_rr_arbiter.sv - round-robin search from ptr producing a one-hot grant
module rr_arbiter #(
    parameter int N  = 4,
    parameter int SW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [SW-1:0] ptr_i,
    output logic [N-1:0]  grant_o
);

    int  p;
    logic found;

    // Visit ptr, ptr+1, ... wrapping at N; the first requester wins.
    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        p       = 0;
        for (int k = 0; k < N; k++) begin
            p = int'(ptr_i) + k;
            if (p >= N) begin
                p = p - N;
            end
            for (int j = 0; j < N; j++) begin
                if (!found && (j == p) && req_i[j]) begin
                    grant_o[j] = 1'b1;
                    found      = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mux_arb_n.sv
// rtl/mux_arb_n.sv - N-channel select/round-robin mux with one registered output stage
module mux_arb_n
    import mux_arb_n_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int N     = 4,
    parameter int MODE  = MODE_SELECT,
    localparam int SW   = sel_width(N)
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [N*WIDTH-1:0]   Hyrja,
    input  logic [N-1:0]         HyrjaValid,
    output logic [N-1:0]         HyrjaGati,
    input  logic [SW-1:0]        S,
    output logic [WIDTH-1:0]     Dalja,
    output logic                 DaljaValid,
    input  logic                 DaljaGati,
    output logic [SW-1:0]        DaljaKanali
);

    logic             load;
    logic             xfer;
    logic [N-1:0]     grant;
    logic [N-1:0]     sel_grant;
    logic [N-1:0]     rr_grant;
    logic [SW-1:0]    idx;
    logic [WIDTH-1:0] mux_data;
    logic [SW-1:0]    ptr_q, ptr_d;
    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic [SW-1:0]    kanali_q;

    assign load = ~valid_q | DaljaGati;

    // Out-of-range selects simply match no channel.
    always_comb begin
        sel_grant = '0;
        for (int i = 0; i < N; i++) begin
            if (S == SW'(i)) begin
                sel_grant[i] = HyrjaValid[i];
            end
        end
    end

    generate
        if (MODE == MODE_RR) begin : g_rr
            rr_arbiter #(
                .N  (N),
                .SW (SW)
            ) u_rr_arbiter (
                .req_i   (HyrjaValid),
                .ptr_i   (ptr_q),
                .grant_o (rr_grant)
            );
        end else begin : g_no_rr
            assign rr_grant = '0;
        end
    endgenerate

    assign grant     = (MODE == MODE_RR) ? rr_grant : sel_grant;
    assign HyrjaGati = Reset ? '0 : (grant & {N{load}});
    assign xfer      = |(HyrjaValid & HyrjaGati);

    always_comb begin
        idx      = '0;
        mux_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                idx      = idx | SW'(i);
                mux_data = mux_data | Hyrja[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if ((MODE == MODE_RR) && xfer) begin
            ptr_d = (idx == SW'(N - 1)) ? '0 : idx + SW'(1);
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            valid_q  <= 1'b0;
            data_q   <= '0;
            kanali_q <= '0;
            ptr_q    <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (load) begin
                if (xfer) begin
                    valid_q  <= 1'b1;
                    data_q   <= mux_data;
                    kanali_q <= idx;
                end else begin
                    valid_q  <= 1'b0;
                end
            end
        end
    end

    assign Dalja       = data_q;
    assign DaljaValid  = valid_q;
    assign DaljaKanali = kanali_q;

endmodule
